writeback_arbiter: RTL and testbench

- Producer side of the register-file write port. It merges two result sources onto the single write port (write_enable / write_address / write_data):
  - the in-order pipeline writeback;
  - a long-latency auxiliary unit (multiply/divide, uncached load return).
- Pipeline writes never stall. Auxiliary results are buffered in a small FIFO and drained into idle write slots.
- A pending-destination bitmap is exported to decode for interlocking.

---
 rtl/writeback_arbiter.sv | 76 +++++++
 tb/tb_writeback_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges pipeline writeback and a buffered auxiliary result stream onto one register-file write port
module writeback_arbiter #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       pipe_valid,
   input  logic [ADDR_WIDTH-1:0]      pipe_address,
   input  logic [DATA_WIDTH-1:0]      pipe_data,
   input  logic                       aux_valid,
   output logic                       aux_ready,
   input  logic [ADDR_WIDTH-1:0]      aux_address,
   input  logic [DATA_WIDTH-1:0]      aux_data,
   output logic                       write_enable,
   output logic [ADDR_WIDTH-1:0]      write_address,
   output logic [DATA_WIDTH-1:0]      write_data,
   output logic [2**ADDR_WIDTH-1:0]   pending_mask,
   output logic [$clog2(DEPTH):0]     fifo_count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
   logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]      live;
   logic [PW-1:0]         rd_ptr, wr_ptr;
   logic [PW:0]           count;
   logic                  pipe_take, pop, push, head_write;
   assign aux_ready  = count < FULL;
   assign fifo_count = count;
   assign pipe_take  = pipe_valid && (pipe_address != '0);
   assign pop        = !pipe_take && (count != '0);
   assign head_write = pop && live[rd_ptr];
   assign push       = aux_valid && aux_ready && (aux_address != '0);
   // live is cleared on pop, so a set bit always marks an occupied, unsquashed entry
   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++)
         if (live[i]) pending_mask[addr_q[i]] = 1'b1;
      pending_mask[0] = 1'b0;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         live          <= '0;
         write_enable  <= 1'b0;
         write_address <= '0;
         write_data    <= '0;
      end else begin
         write_enable <= pipe_take || head_write;
         if (pipe_take) begin
            write_address <= pipe_address;
            write_data    <= pipe_data;
         end else if (head_write) begin
            write_address <= addr_q[rd_ptr];
            write_data    <= data_q[rd_ptr];
         end
         for (int i = 0; i < DEPTH; i++)
            if (pipe_take && addr_q[i] == pipe_address) live[i] <= 1'b0;
         if (pop) begin
            live[rd_ptr] <= 1'b0;
            rd_ptr       <= rd_ptr + 1'b1;
         end
         if (push) begin
            addr_q[wr_ptr] <= aux_address;
            data_q[wr_ptr] <= aux_data;
            live[wr_ptr]   <= !(pipe_take && aux_address == pipe_address);
            wr_ptr         <= wr_ptr + 1'b1;
         end
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: randomized scoreboard bench against a queue-based model of the write port
module tb_writeback_arbiter;
   localparam int DEPTH = 4;
   logic        clock, reset;
   logic        pipe_valid, aux_valid, aux_ready, write_enable;
   logic [4:0]  pipe_address, aux_address, write_address;
   logic [31:0] pipe_data, aux_data, write_data, pending_mask;
   logic [2:0]  fifo_count;
   writeback_arbiter #(.DEPTH(DEPTH), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clock(clock), .reset(reset),
      .pipe_valid(pipe_valid), .pipe_address(pipe_address), .pipe_data(pipe_data),
      .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_address(aux_address), .aux_data(aux_data),
      .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
      .pending_mask(pending_mask), .fifo_count(fifo_count)
   );
   typedef struct { logic [4:0] a; logic [31:0] d; bit live; } ent_t;
   typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
   ent_t mq[$];
   wr_t  eq[$];
   int total = 0, bad = 0;
   bit rst_prev = 1, mon_on = 0;
   logic [4:0]  last_a = 0;
   logic [31:0] last_d = 0;
   logic acc;
   initial clock = 0;
   always #5 clock = ~clock;
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [31:0] model_mask();
      logic [31:0] m = 0;
      foreach (mq[i]) if (mq[i].live) m[mq[i].a] = 1'b1;
      m[0] = 1'b0;
      return m;
   endfunction
   // one clock of stimulus: check state after the edge, drive inputs, advance the model
   task automatic step(input logic r, input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad, output logic accepted);
      bit take;
      ent_t e;
      @(posedge clock);
      #1;
      if (rst_prev) begin
         last_a = 0;
         last_d = 0;
         mon_on = 1;
         check("reset_we", write_enable, 0);
         check("reset_addr", write_address, 0);
         check("reset_data", write_data, 0);
      end
      check("fifo_count", fifo_count, mq.size());
      check("aux_ready", aux_ready, mq.size() < DEPTH);
      check("pending_mask", pending_mask, model_mask());
      reset = r; pipe_valid = pv; pipe_address = pa; pipe_data = pd;
      aux_valid = av; aux_address = aa; aux_data = ad;
      accepted = av && (mq.size() < DEPTH);
      if (r) begin
         mq.delete();
         accepted = 0;
      end else begin
         take = pv && pa != 0;
         if (take) begin
            eq.push_back('{pa, pd});
            foreach (mq[i]) if (mq[i].a == pa) mq[i].live = 0;
         end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.live) eq.push_back('{e.a, e.d});
         end
         if (accepted && aa != 0) mq.push_back('{aa, ad, !(take && aa == pa)});
      end
      rst_prev = r;
   endtask
   always @(negedge clock) begin
      wr_t w;
      if (mon_on) begin
         if (write_enable === 1'b1) begin
            if (eq.size() == 0) check("unexpected_write", 1, 0);
            else begin
               w = eq.pop_front();
               check("write_address", write_address, w.a);
               check("write_data", write_data, w.d);
               last_a = w.a;
               last_d = w.d;
            end
         end else begin
            check("hold_we", write_enable, 0);
            check("hold_address", write_address, last_a);
            check("hold_data", write_data, last_d);
         end
      end
   end
   initial begin
      int k;
      reset = 1; pipe_valid = 0; pipe_address = 0; pipe_data = 0;
      aux_valid = 0; aux_address = 0; aux_data = 0;
      step(1, 0, 0, 0, 0, 0, 0, acc);
      step(0, 0, 0, 0, 0, 0, 0, acc);
      step(0, 1, 5, 32'h1234, 0, 0, 0, acc);
      step(0, 1, 0, 32'h5555, 0, 0, 0, acc);
      step(0, 0, 0, 0, 1, 7, 32'hAAAA, acc);
      repeat (3) step(0, 0, 0, 0, 0, 0, 0, acc);
      k = 0;
      for (int p = 1; p <= 6; p++) begin
         step(0, 1, 5'(p), 32'(p * 16), k < 4, 5'(8 + k), 32'(8 + k), acc);
         if (acc) k++;
      end
      repeat (6) step(0, 0, 0, 0, 0, 0, 0, acc);
      step(0, 1, 1, 32'h11, 1, 9, 32'h1, acc);
      step(0, 1, 9, 32'h2, 0, 0, 0, acc);
      repeat (3) step(0, 0, 0, 0, 0, 0, 0, acc);
      step(0, 1, 3, 32'hC, 1, 3, 32'hB, acc);
      repeat (3) step(0, 0, 0, 0, 0, 0, 0, acc);
      step(0, 1, 1, 32'h21, 1, 10, 32'hA0, acc);
      step(0, 1, 2, 32'h22, 1, 12, 32'hC0, acc);
      step(0, 1, 4, 32'h24, 1, 13, 32'hD0, acc);
      step(1, 0, 0, 0, 0, 0, 0, acc);
      repeat (4) step(0, 0, 0, 0, 0, 0, 0, acc);
      for (int n = 0; n < 3000; n++)
         step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom, acc);
      repeat (10) step(0, 0, 0, 0, 0, 0, 0, acc);
      @(negedge clock);
      #1;
      check("drained", eq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
